// File: rtl/char_stream_sequencer_pkg.sv
// Shared types and defaults for the character stream sequencer.
package char_stream_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_STREAM,
    ST_DRAIN,
    ST_DONE
  } state_t;

  localparam int CHAR_W        = 8;
  // FIFO entries carry {eof, char}; the eof flag sits above the character.
  localparam int EOF_BIT       = CHAR_W;
  localparam int ENTRY_W       = CHAR_W + 1;
  localparam int COUNT_W       = 16;
  localparam int DEFAULT_DEPTH = 4;
  localparam int DEFAULT_DRAIN = 1;
  localparam int DEFAULT_RW    = 16;

endpackage

// File: rtl/char_stream_sequencer_if.sv
// Upstream valid/ready character stream (file/UART reader -> sequencer).
interface char_stream_sequencer_if;
  import char_stream_sequencer_pkg::*;

  logic [CHAR_W-1:0] in_char;
  logic              in_eof;
  logic              in_valid;
  logic              in_ready;

  modport master (output in_char, output in_eof, output in_valid, input in_ready);
  modport slave  (input in_char, input in_eof, input in_valid, output in_ready);

endinterface

// File: rtl/char_stream_sequencer_char_fifo.sv
// Small synchronous FIFO; pointers carry an extra MSB to tell full from empty.
module char_fifo
  import char_stream_sequencer_pkg::*;
#(
  parameter int WIDTH = ENTRY_W,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // Head entry is visible combinationally; the consumer registers it.
  assign rdata   = mem[rd_ptr[AW-1:0]];

  // Pointer update; flush empties the FIFO without touching storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage write; data needs no reset since pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/char_stream_sequencer.sv
// Sequences buffered upstream characters into the character datapath,
// clears it per run, detects end-of-input and captures the result.
module char_stream_sequencer
  import char_stream_sequencer_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int DRAIN = DEFAULT_DRAIN,
  parameter int RW    = DEFAULT_RW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               hold,
  char_stream_sequencer_if.slave up,
  output logic [CHAR_W-1:0]  dp_character,
  output logic               dp_enable,
  output logic               dp_rst,
  input  logic [RW-1:0]      dp_result,
  output logic [RW-1:0]      result,
  output logic [COUNT_W-1:0] char_count,
  output logic               busy,
  output logic               done
);

  localparam int CW = $clog2(DRAIN + 1);

  state_t               state;
  logic                 eof_accepted;
  logic [CW-1:0]        drain_cnt;
  logic                 push;
  logic                 pop;
  logic                 flush;
  logic                 full;
  logic                 empty;
  logic [ENTRY_W-1:0]   head;

  // Ready depends on registered state only, so a same-cycle pop never
  // opens a slot in a full FIFO and no input reaches an output directly.
  assign up.in_ready = (state == ST_STREAM) && !full && !eof_accepted;
  assign push        = up.in_valid && up.in_ready;
  assign pop         = (state == ST_STREAM) && !empty && !hold;
  assign flush       = (state == ST_CLEAR);

  char_fifo #(.WIDTH(ENTRY_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (push),
    .wdata ({up.in_eof, up.in_char}),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  // Run control FSM with registered datapath strobes, count and result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      eof_accepted <= 1'b0;
      drain_cnt    <= '0;
      dp_rst       <= 1'b1;
      dp_enable    <= 1'b0;
      dp_character <= '0;
      char_count   <= '0;
      result       <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      dp_enable <= 1'b0;
      dp_rst    <= 1'b0;
      if (push && up.in_eof) eof_accepted <= 1'b1;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state        <= ST_CLEAR;
            dp_rst       <= 1'b1;
            busy         <= 1'b1;
            done         <= 1'b0;
            char_count   <= '0;
            eof_accepted <= 1'b0;
          end
        end
        ST_CLEAR: state <= ST_STREAM;
        ST_STREAM: begin
          if (pop) begin
            if (head[EOF_BIT]) begin
              state     <= ST_DRAIN;
              drain_cnt <= '0;
            end else begin
              dp_enable    <= 1'b1;
              dp_character <= head[CHAR_W-1:0];
              char_count   <= char_count + COUNT_W'(1);
            end
          end
        end
        ST_DRAIN: begin
          // Let the datapath settle before sampling its result.
          if (drain_cnt == CW'(DRAIN)) begin
            state  <= ST_DONE;
            result <= dp_result;
            busy   <= 1'b0;
            done   <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + CW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_char_stream_sequencer.sv
// Randomized bench for char_stream_sequencer with a queue-based reference
// model, a summing stub datapath and a few hand-computed anchors.
module tb_char_stream_sequencer;

  localparam int DEPTH = 4;
  localparam int DRAIN = 3;
  localparam int RW    = 16;

  localparam int P_IDLE = 0, P_CLEAR = 1, P_STREAM = 2, P_DRAIN = 3, P_DONE = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          hold;
  logic [7:0]    dp_character;
  logic          dp_enable;
  logic          dp_rst;
  logic [RW-1:0] dp_result;
  logic [RW-1:0] result;
  logic [15:0]   char_count;
  logic          busy;
  logic          done;

  char_stream_sequencer_if up_if();

  char_stream_sequencer #(.DEPTH(DEPTH), .DRAIN(DRAIN), .RW(RW)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .hold         (hold),
    .up           (up_if),
    .dp_character (dp_character),
    .dp_enable    (dp_enable),
    .dp_rst       (dp_rst),
    .dp_result    (dp_result),
    .result       (result),
    .char_count   (char_count),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  // Stub datapath: running sum of delivered characters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            dp_result <= '0;
    else if (dp_rst)    dp_result <= '0;
    else if (dp_enable) dp_result <= dp_result + RW'(dp_character);
  end

  // Reference model state
  int        phase;
  int        drain_edges;
  bit        eof_in;
  bit [8:0]  fq[$];
  bit        e_en;
  bit        e_dprst;
  bit [7:0]  e_char;
  bit [15:0] e_count;
  bit [15:0] e_result;
  bit [15:0] m_sum;
  bit        last_acc;

  // Stimulus and observation
  bit [8:0]  stim[$];
  bit [7:0]  got_q[$];
  int        en_cnt;
  int        en_run;
  int        en_max;
  int        total = 0;
  int        bad = 0;
  bit        chk_on = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_ready();
    return (phase == P_STREAM) && (fq.size() < DEPTH) && !eof_in;
  endfunction

  task automatic m_reset();
    phase = P_IDLE; fq.delete(); eof_in = 0; drain_edges = 0;
    e_en = 0; e_dprst = 1; e_char = 0; e_count = 0; e_result = 0; m_sum = 0;
  endtask

  // One clock edge of the reference behaviour, using pre-edge inputs.
  task automatic model_edge();
    bit        rdy;
    bit [8:0]  ent;
    bit [15:0] pre_sum;
    if (rst) begin
      m_reset();
      last_acc = 0;
      return;
    end
    rdy     = m_ready();
    pre_sum = m_sum;
    if (e_dprst)   m_sum = 0;
    else if (e_en) m_sum = m_sum + 16'(e_char);
    e_en = 0;
    e_dprst = 0;
    case (phase)
      P_IDLE, P_DONE: if (start) begin
        phase = P_CLEAR; e_dprst = 1; e_count = 0; eof_in = 0;
      end
      P_CLEAR: begin
        phase = P_STREAM; fq.delete();
      end
      P_STREAM: if (fq.size() > 0 && !hold) begin
        ent = fq.pop_front();
        if (ent[8]) begin
          phase = P_DRAIN; drain_edges = 0;
        end else begin
          e_en = 1; e_char = ent[7:0]; e_count = e_count + 16'd1;
        end
      end
      P_DRAIN: begin
        drain_edges++;
        if (drain_edges == DRAIN + 1) begin
          e_result = pre_sum; phase = P_DONE;
        end
      end
      default: ;
    endcase
    last_acc = up_if.in_valid && rdy;
    if (last_acc) begin
      fq.push_back({up_if.in_eof, up_if.in_char});
      if (up_if.in_eof) eof_in = 1;
    end
  endtask

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("in_ready", up_if.in_ready, m_ready());
      chk("dp_enable", dp_enable, e_en);
      chk("dp_character", dp_character, e_char);
      chk("dp_rst", dp_rst, e_dprst);
      chk("result", result, e_result);
      chk("char_count", char_count, e_count);
      chk("busy", busy, (phase >= P_CLEAR) && (phase <= P_DRAIN));
      chk("done", done, phase == P_DONE);
      chk("dp_sum", dp_result, m_sum);
    end
  end

  task automatic step(input bit st, input bit hd, input bit v, input bit [7:0] c, input bit e);
    start = st; hold = hd; up_if.in_valid = v; up_if.in_char = c; up_if.in_eof = e;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    if (dp_enable) begin
      en_cnt++; en_run++; got_q.push_back(dp_character);
      if (en_run > en_max) en_max = en_run;
    end else begin
      en_run = 0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 8'h00, 0);
  endtask

  task automatic clear_obs();
    got_q.delete(); en_cnt = 0; en_run = 0; en_max = 0; stim.delete();
  endtask

  // Offer stim beats until the model reports the run complete.
  task automatic feed(input bit do_start, input int pv, input int ph, input int ps, input int budget);
    int guard;
    if (do_start) step(1, 0, 0, 8'h00, 0);
    guard = 0;
    while (phase != P_DONE && guard < budget) begin
      bit st, hd, v;
      bit [8:0] b;
      st = (phase >= P_CLEAR) && (phase <= P_DRAIN) && ($urandom_range(99) < ps);
      hd = $urandom_range(99) < ph;
      v  = $urandom_range(99) < pv;
      if (stim.size() > 0) b = stim[0];
      else                 b = {1'b0, 8'($urandom)};
      step(st, hd, v, b[7:0], b[8]);
      if (last_acc && stim.size() > 0) void'(stim.pop_front());
      guard++;
    end
    chk("run_done", done, 1);
  endtask

  initial begin
    int acc;
    int edges;
    bit eof_sent;
    int len;

    rst = 1; start = 0; hold = 0;
    up_if.in_valid = 0; up_if.in_char = 0; up_if.in_eof = 0;
    m_reset();
    chk_on = 1;
    repeat (2) @(negedge clk);
    chk("reset_dp_rst", dp_rst, 1);
    chk("reset_in_ready", up_if.in_ready, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_count", char_count, 0);
    rst = 0;
    idle(2);
    chk("idle_dp_rst", dp_rst, 0);

    // "abc" then eof into the summing stub
    clear_obs();
    stim.push_back(9'h061); stim.push_back(9'h062); stim.push_back(9'h063); stim.push_back(9'h100);
    feed(1, 100, 0, 0, 200);
    chk("abc_count", char_count, 3);
    chk("abc_result", result, 294);
    chk("abc_en_cycles", en_cnt, 3);
    chk("abc_en_run", en_max, 3);
    chk("abc_first", got_q[0], 8'h61);
    chk("abc_last", got_q[2], 8'h63);

    // Empty input: start then eof only
    clear_obs();
    step(1, 0, 0, 8'h00, 0);
    edges = 0; eof_sent = 0;
    while (!done && edges < 50) begin
      step(0, 0, !eof_sent, 8'h00, 1);
      if (last_acc) eof_sent = 1;
      edges++;
    end
    chk("empty_latency", edges, 3 + 1 + DRAIN);
    chk("empty_en", en_cnt, 0);
    chk("empty_count", char_count, 0);
    chk("empty_result", result, 0);

    // Hold with a filling FIFO, then release and check ordering
    clear_obs();
    for (int i = 0; i < 6; i++) stim.push_back({1'b0, 8'(8'h30 + i)});
    stim.push_back(9'h100);
    step(1, 0, 0, 8'h00, 0);
    acc = 0;
    for (int k = 0; k < 10; k++) begin
      if (up_if.in_ready) acc++;
      step(0, 1, 1, stim[0][7:0], stim[0][8]);
      if (last_acc) void'(stim.pop_front());
    end
    chk("hold_accepts", acc, 4);
    feed(0, 100, 0, 0, 200);
    chk("hold_len", got_q.size(), 6);
    for (int i = 0; i < 6; i++) chk("hold_order", got_q[i], 8'h30 + i);

    // Randomized runs with hold, gaps, stray starts and post-eof beats
    for (int r = 0; r < 10; r++) begin
      clear_obs();
      len = $urandom_range(0, 12);
      for (int i = 0; i < len; i++) stim.push_back({1'b0, 8'($urandom)});
      stim.push_back(9'h100);
      feed(1, 70, 30, 20, 2000);
      chk("rand_count", char_count, len);
      idle($urandom_range(0, 2));
    end

    // Reset in the middle of a run with three entries buffered
    clear_obs();
    stim.push_back(9'h070); stim.push_back(9'h071);
    step(1, 0, 0, 8'h00, 0);
    for (int k = 0; k < 20 && stim.size() > 0; k++) begin
      step(0, 0, 1, stim[0][7:0], 0);
      if (last_acc) void'(stim.pop_front());
    end
    idle(3);
    stim.push_back(9'h078); stim.push_back(9'h079); stim.push_back(9'h07a);
    for (int k = 0; k < 20 && stim.size() > 0; k++) begin
      step(0, 1, 1, stim[0][7:0], 0);
      if (last_acc) void'(stim.pop_front());
    end
    chk("pre_reset_count", char_count, 2);
    #2 rst = 1;
    m_reset();
    #1;
    chk("mid_rst_dp_rst", dp_rst, 1);
    chk("mid_rst_enable", dp_enable, 0);
    chk("mid_rst_char", dp_character, 0);
    chk("mid_rst_ready", up_if.in_ready, 0);
    chk("mid_rst_count", char_count, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_result", result, 0);
    @(negedge clk);
    rst = 0;
    idle(2);
    clear_obs();
    stim.push_back(9'h06b); stim.push_back(9'h100);
    feed(1, 100, 0, 0, 200);
    chk("after_rst_count", char_count, 1);
    chk("after_rst_result", result, 16'h6b);

    // 65537 characters wrap the count; sum of ones wraps the same way
    clear_obs();
    for (int i = 0; i < 65537; i++) stim.push_back(9'h001);
    stim.push_back(9'h100);
    feed(1, 100, 0, 0, 70000);
    chk("wrap_count", char_count, 1);
    chk("wrap_result", result, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
